// File: rtl/axi_lite_led_regs_pkg.sv
// Shared types and constants for the AXI4-Lite LED register block.
// Contents: register index type and names, the OKAY response code,
// write/read FSM state types and the WSTRB byte-merge helper.
package axi_lite_led_regs_pkg;

  typedef logic [1:0] reg_idx_t;

  localparam reg_idx_t REG_LED     = 2'd0;
  localparam reg_idx_t REG_MASK    = 2'd1;
  localparam reg_idx_t REG_PRESC   = 2'd2;
  localparam reg_idx_t REG_SCRATCH = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Take each byte from new_val where its strobe is set, otherwise keep old_val.
  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_led_regs_if.sv
// AXI4-Lite bus bundle between the master (testbench/VIP) and the LED register slave.
// Signals: AW (AWADDR/AWPROT/AWVALID/AWREADY), W (WDATA/WSTRB/WVALID/WREADY),
// B (BRESP/BVALID/BREADY), AR (ARADDR/ARPROT/ARVALID/ARREADY), R (RDATA/RRESP/RVALID/RREADY).
// Modports: master drives requests, slave drives READYs and responses.
interface axi_lite_led_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_led_regs_led_blinker.sv
// Blink generator: a prescaler counting 0..presc toggles a phase bit on each wrap;
// while phase is 0 the LEDs selected by mask are blanked. Output is registered.
// Ports: clk, rst (sync, active-high), presc_wr (reload pulse on a prescaler write),
// presc (wrap value), pattern (LED pattern), mask (blink mask), leds (LED drive).
module led_blinker #(
  parameter int C_NUM_LEDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  presc_wr,
  input  logic [31:0]           presc,
  input  logic [C_NUM_LEDS-1:0] pattern,
  input  logic [C_NUM_LEDS-1:0] mask,
  output logic [C_NUM_LEDS-1:0] leds
);

  logic [31:0]           cnt_r;
  logic                  phase_r;
  logic [C_NUM_LEDS-1:0] blank_s;
  logic [C_NUM_LEDS-1:0] leds_r;

  // Prescaler and phase; a prescaler write restarts the blink in the "on" phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b1;
    end else if (presc_wr) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b1;
    end else if (cnt_r == presc) begin
      cnt_r   <= 32'd0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + 32'd1;
      phase_r <= phase_r;
    end
  end

  // Blank mask is active only in the "off" phase.
  always_comb begin
    blank_s = {C_NUM_LEDS{1'b0}};
    if (phase_r) begin
      blank_s = {C_NUM_LEDS{1'b0}};
    end else begin
      blank_s = mask;
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_r <= {C_NUM_LEDS{1'b0}};
    end else begin
      leds_r <= pattern & ~blank_s;
    end
  end

  assign leds = leds_r;

endmodule

// File: rtl/axi_lite_led_regs.sv
// AXI4-Lite slave with four 32-bit RW registers driving board LEDs.
// reg0 = LED pattern, reg1 = blink mask, reg2 = blink prescaler, reg3 = scratch.
// Ports: ACLK, ARESET (sync, active-high), s_axi (slave modport of
// axi_lite_led_regs_if), LEDS (registered LED drive, C_NUM_LEDS wide).
// Build option: define LEDS_BLINK_EN to add the prescaler/blink logic (led_blinker);
// without it LEDS simply follow reg0 and reg1/reg2 are plain storage.
module axi_lite_led_regs
  import axi_lite_led_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_NUM_LEDS         = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi_lite_led_regs_if.slave    s_axi,
  output logic [C_NUM_LEDS-1:0] LEDS
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_r [4];

  wr_state_t                     wr_state_r;
  logic                          awready_r, wready_r, bvalid_r;
  logic                          aw_held_r, w_held_r;
  reg_idx_t                      awidx_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_r;
  logic [3:0]                    wstrb_r;

  rd_state_t                     rd_state_r;
  logic                          arready_r, rvalid_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;

  logic                          aw_hs_s, w_hs_s, aw_have_s, w_have_s, do_write_s;
  reg_idx_t                      wr_idx_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_s;
  logic [3:0]                    wr_strb_s;
  logic                          unused_s;

  // Write-path combine: a beat may come from the held copy or from the bus this cycle.
  always_comb begin
    aw_hs_s    = s_axi.AWVALID && awready_r;
    w_hs_s     = s_axi.WVALID && wready_r;
    aw_have_s  = aw_held_r || aw_hs_s;
    w_have_s   = w_held_r || w_hs_s;
    do_write_s = (wr_state_r == W_IDLE) && aw_have_s && w_have_s;
    wr_idx_s   = aw_held_r ? awidx_r : s_axi.AWADDR[3:2];
    wr_data_s  = w_held_r ? wdata_r : s_axi.WDATA;
    wr_strb_s  = w_held_r ? wstrb_r : s_axi.WSTRB;
  end

  // Write FSM: collect AW and W independently, then hold BVALID until BREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      awidx_r    <= 2'd0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (do_write_s) begin
            wr_state_r <= W_RESP;
            bvalid_r   <= 1'b1;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
          end else begin
            aw_held_r <= aw_have_s;
            w_held_r  <= w_have_s;
            awready_r <= !aw_have_s;
            wready_r  <= !w_have_s;
            if (aw_hs_s) begin
              awidx_r <= s_axi.AWADDR[3:2];
            end
            if (w_hs_s) begin
              wdata_r <= s_axi.WDATA;
              wstrb_r <= s_axi.WSTRB;
            end
          end
        end
        W_RESP: begin
          if (s_axi.BREADY) begin
            wr_state_r <= W_IDLE;
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
          end
        end
        default: begin
          wr_state_r <= W_IDLE;
          bvalid_r   <= 1'b0;
          awready_r  <= 1'b0;
          wready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Register file with byte-strobe merge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (do_write_s) begin
      regs_r[wr_idx_s] <= wstrb_merge(regs_r[wr_idx_s], wr_data_s, wr_strb_s);
    end
  end

  // Read FSM: capture the pre-write register value on AR, hold RDATA until RREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'd0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (s_axi.ARVALID && arready_r) begin
            rdata_r    <= regs_r[s_axi.ARADDR[3:2]];
            rvalid_r   <= 1'b1;
            arready_r  <= 1'b0;
            rd_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.RREADY) begin
            rvalid_r   <= 1'b0;
            arready_r  <= 1'b1;
            rd_state_r <= R_IDLE;
          end
        end
        default: begin
          rd_state_r <= R_IDLE;
          rvalid_r   <= 1'b0;
          arready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi.AWREADY = awready_r;
  assign s_axi.WREADY  = wready_r;
  assign s_axi.BVALID  = bvalid_r;
  assign s_axi.BRESP   = AXI_RESP_OKAY;
  assign s_axi.ARREADY = arready_r;
  assign s_axi.RVALID  = rvalid_r;
  assign s_axi.RDATA   = rdata_r;
  assign s_axi.RRESP   = AXI_RESP_OKAY;

  // Protection bits and byte offset within the word carry no meaning here.
  assign unused_s = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

`ifdef LEDS_BLINK_EN
  logic presc_wr_s;
  assign presc_wr_s = do_write_s && (wr_idx_s == REG_PRESC);

  led_blinker #(.C_NUM_LEDS(C_NUM_LEDS)) u_blinker (
    .clk      (ACLK),
    .rst      (ARESET),
    .presc_wr (presc_wr_s),
    .presc    (regs_r[REG_PRESC]),
    .pattern  (regs_r[REG_LED][C_NUM_LEDS-1:0]),
    .mask     (regs_r[REG_MASK][C_NUM_LEDS-1:0]),
    .leds     (LEDS)
  );
`else
  logic [C_NUM_LEDS-1:0] leds_r;

  // Registered LED drive straight from the pattern register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      leds_r <= {C_NUM_LEDS{1'b0}};
    end else begin
      leds_r <= regs_r[REG_LED][C_NUM_LEDS-1:0];
    end
  end

  assign LEDS = leds_r;
`endif

endmodule
